// File: rtl/uart_tx_frame_if.sv
// Byte-source handshake into the UART transmitter: valid/ready plus payload.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    // Producer side (packetiser)
    modport master (output tx_valid, output tx_data, input tx_ready);
    // Consumer side (transmitter)
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload bits LSB first,
// optional odd/even parity bit, one or two stop bits. Each bit lasts
// CLK_FREQ/BAUD clock cycles. The line output is registered.
module uart_tx_frame #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS = 1
) (
    input  logic           Clk,
    input  logic           reset_n,
    uart_tx_frame_if.slave tx_if,
    output logic           serial,
    output logic           tx_busy,
    output logic           tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    // Refuse to build with parameters the frame format cannot express
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_frame: DATA_BITS must be in 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_frame: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_frame: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     baud_cnt, baud_d;
    logic [IDX_W-1:0]     bit_idx, bit_idx_d;   // data bit index, reused as stop-bit index
    logic [DATA_BITS-1:0] data_q;
    logic                 parity_q;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;

    logic tick;
    logic accept;
    logic last_data;
    logic last_stop;

    assign tick      = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign accept    = tx_if.tx_valid && (state == S_IDLE);
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));

    // State, baud counter and bit index registers
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_idx  <= bit_idx_d;
        end
    end

    // Next-state logic: every bit ends on the baud terminal count
    always_comb begin
        state_d   = state;
        bit_idx_d = bit_idx;
        // Counter idles at 0 and restarts at every bit boundary
        baud_d    = (state == S_IDLE || tick) ? '0 : baud_cnt + 1'b1;
        case (state)
            S_IDLE: begin
                bit_idx_d = '0;
                if (accept) state_d = S_START;
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (last_data) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d   = S_STOP;
                    bit_idx_d = '0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        state_d   = S_IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // Outputs: line level for the coming cycle, handshake and status
    always_comb begin
        // Line value is looked up from the next state so the register
        // changes on the same edge as the state
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = data_q[bit_idx_d];
            S_PARITY: serial_d = parity_q;
            default:  serial_d = 1'b1;
        endcase
        done_d         = (state == S_STOP) && tick && last_stop;
        tx_if.tx_ready = (state == S_IDLE);
        tx_busy        = (state != S_IDLE);
    end

    // Payload capture at acceptance, registered line and done pulse
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= '0;
            parity_q <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            if (accept) begin
                data_q   <= tx_if.tx_data;
                parity_q <= (PARITY == 1) ? ~^tx_if.tx_data : ^tx_if.tx_data;
            end
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign serial  = serial_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances (8N1, 8E1, 8O1, 5N2) at
// 10 clocks per bit, sharing clock and reset.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_frame_if #(.DATA_BITS(8)) if_8n1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_8e1 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if_8o1 ();
    uart_tx_frame_if #(.DATA_BITS(5)) if_5n2 ();

    logic [3:0] ser, busy, done, rdy;
    assign rdy = {if_5n2.tx_ready, if_8o1.tx_ready, if_8e1.tx_ready, if_8n1.tx_ready};

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u_8n1 (.Clk(clk), .reset_n(rst_n), .tx_if(if_8n1.slave),
               .serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        u_8e1 (.Clk(clk), .reset_n(rst_n), .tx_if(if_8e1.slave),
               .serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        u_8o1 (.Clk(clk), .reset_n(rst_n), .tx_if(if_8o1.slave),
               .serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2))
        u_5n2 (.Clk(clk), .reset_n(rst_n), .tx_if(if_5n2.slave),
               .serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    int tests = 0;
    int fails = 0;
    int sel = 0;
    logic line [0:299];
    logic dn   [0:299];
    logic bz   [0:299];
    logic rd   [0:299];

    task automatic drive(input int s, input logic v, input logic [8:0] d);
        case (s)
            0:       begin if_8n1.tx_valid = v; if_8n1.tx_data = d[7:0]; end
            1:       begin if_8e1.tx_valid = v; if_8e1.tx_data = d[7:0]; end
            2:       begin if_8o1.tx_valid = v; if_8o1.tx_data = d[7:0]; end
            default: begin if_5n2.tx_valid = v; if_5n2.tx_data = d[4:0]; end
        endcase
    endtask

    // One-cycle valid pulse; returns at the negedge after the accepting edge
    task automatic send(input int s, input logic [8:0] d);
        sel = s;
        drive(s, 1'b1, d);
        @(negedge clk);
        drive(s, 1'b0, d);
    endtask

    // Sample the selected instance once per cycle, at negedges
    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            line[i] = ser[sel];
            dn[i]   = done[sel];
            bz[i]   = busy[sel];
            rd[i]   = rdy[sel];
            @(negedge clk);
        end
    endtask

    // Mid-bit value of each 10-cycle slot, plus count of slots not held steady
    task automatic decode(input int base, input int nbits, output logic [15:0] obs,
                          output int unstable);
        obs = '0;
        unstable = 0;
        for (int k = 0; k < nbits; k++) begin
            obs[k] = line[base + k*10 + 5];
            for (int c = 0; c < 10; c++)
                if (line[base + k*10 + c] !== obs[k]) unstable++;
        end
    endtask

    function automatic int count_done(input int from, input int upto);
        int n = 0;
        for (int i = from; i < upto; i++) if (dn[i] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 9'h000);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            tests++;
            if ({ser[s], rdy[s], busy[s], done[s]} !== 4'b1100) begin
                fails++;
                $display("FAIL reset_state inst%0d: ser/rdy/busy/done=%b want 1100", s,
                         {ser[s], rdy[s], busy[s], done[s]});
            end
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_release: got %b want 1", rdy[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [15:0] obs;
        int u;
        send(0, 9'h0A5);
        record(103);
        decode(0, 10, obs, u);
        tests++;
        if (obs[9:0] !== 10'b1101001010 || u !== 0) begin
            fails++;
            $display("FAIL 8n1_a5_bits: got %b unstable %0d want 1101001010 unstable 0", obs[9:0], u);
        end
        tests++;
        if (bz[0] !== 1'b1 || rd[0] !== 1'b0) begin
            fails++;
            $display("FAIL 8n1_busy_in_frame: busy %b ready %b want 1 0", bz[0], rd[0]);
        end
        tests++;
        if (dn[100] !== 1'b1 || count_done(0, 103) !== 1) begin
            fails++;
            $display("FAIL 8n1_done: done@100=%b count=%0d want 1 1", dn[100], count_done(0, 103));
        end
        tests++;
        if (bz[100] !== 1'b0 || rd[100] !== 1'b1 || bz[99] !== 1'b1) begin
            fails++;
            $display("FAIL 8n1_end_status: busy99 %b busy100 %b ready100 %b want 1 0 1",
                     bz[99], bz[100], rd[100]);
        end
    endtask

    task automatic test_parity();
        logic [15:0] obs;
        int u;
        send(1, 9'h007);
        record(113);
        decode(0, 11, obs, u);
        tests++;
        if (obs[10:0] !== 11'b11000001110 || u !== 0) begin
            fails++;
            $display("FAIL 8e1_07_bits: got %b unstable %0d want 11000001110", obs[10:0], u);
        end
        tests++;
        if (dn[110] !== 1'b1 || count_done(0, 113) !== 1) begin
            fails++;
            $display("FAIL 8e1_length: done@110=%b count=%0d want 1 1", dn[110], count_done(0, 113));
        end
        send(2, 9'h007);
        record(113);
        decode(0, 11, obs, u);
        tests++;
        if (obs[10:0] !== 11'b10000001110 || u !== 0) begin
            fails++;
            $display("FAIL 8o1_07_bits: got %b unstable %0d want 10000001110", obs[10:0], u);
        end
        tests++;
        if (dn[110] !== 1'b1 || count_done(0, 113) !== 1) begin
            fails++;
            $display("FAIL 8o1_length: done@110=%b count=%0d want 1 1", dn[110], count_done(0, 113));
        end
    endtask

    task automatic test_5n2();
        logic [15:0] obs;
        int u;
        send(3, 9'h1FF);
        record(83);
        decode(0, 8, obs, u);
        tests++;
        if (obs[7:0] !== 8'b11111110 || u !== 0) begin
            fails++;
            $display("FAIL 5n2_1f_bits: got %b unstable %0d want 11111110", obs[7:0], u);
        end
        tests++;
        if (dn[80] !== 1'b1 || count_done(0, 83) !== 1) begin
            fails++;
            $display("FAIL 5n2_length: done@80=%b count=%0d want 1 1", dn[80], count_done(0, 83));
        end
        send(3, 9'h0EA);
        record(83);
        decode(0, 8, obs, u);
        tests++;
        if (obs[7:0] !== 8'b11010100 || u !== 0) begin
            fails++;
            $display("FAIL 5n2_0a_bits: got %b unstable %0d want 11010100", obs[7:0], u);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] obs1, obs2;
        int u1, u2;
        sel = 0;
        drive(0, 1'b1, 9'h011);
        @(negedge clk);
        drive(0, 1'b1, 9'h022);
        fork
            record(205);
            begin
                repeat (150) @(negedge clk);
                drive(0, 1'b0, 9'h022);
            end
        join
        decode(0, 10, obs1, u1);
        decode(101, 10, obs2, u2);
        tests++;
        if (obs1[9:0] !== 10'b1000100010 || u1 !== 0) begin
            fails++;
            $display("FAIL b2b_first_0x11: got %b unstable %0d want 1000100010", obs1[9:0], u1);
        end
        tests++;
        if (obs2[9:0] !== 10'b1001000100 || u2 !== 0) begin
            fails++;
            $display("FAIL b2b_second_0x22: got %b unstable %0d want 1001000100", obs2[9:0], u2);
        end
        tests++;
        if (line[100] !== 1'b1 || line[101] !== 1'b0 || dn[100] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_gap: line100 %b line101 %b done100 %b want 1 0 1",
                     line[100], line[101], dn[100]);
        end
        tests++;
        if (dn[201] !== 1'b1 || count_done(0, 205) !== 2) begin
            fails++;
            $display("FAIL b2b_done: done@201=%b count=%0d want 1 2", dn[201], count_done(0, 205));
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] obs;
        int u;
        int highs;
        send(0, 9'h000);
        repeat (35) @(negedge clk);
        tests++;
        if (ser[0] !== 1'b0) begin
            fails++;
            $display("FAIL midrst_in_data: line got %b want 0", ser[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (ser[0] !== 1'b1 || rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL midrst_async: ser/rdy/busy=%b want 110", {ser[0], rdy[0], busy[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        record(30);
        highs = 0;
        for (int i = 0; i < 30; i++) if (line[i] === 1'b1) highs++;
        tests++;
        if (count_done(0, 30) !== 0 || highs !== 30) begin
            fails++;
            $display("FAIL midrst_quiet: done count %0d high cycles %0d want 0 30",
                     count_done(0, 30), highs);
        end
        send(0, 9'h03C);
        record(103);
        decode(0, 10, obs, u);
        tests++;
        if (obs[9:0] !== 10'b1001111000 || u !== 0 || dn[100] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_next_frame: got %b unstable %0d done %b want 1001111000 0 1",
                     obs[9:0], u, dn[100]);
        end
    endtask

    task automatic test_data_change();
        logic [15:0] obs;
        int u;
        send(0, 9'h0A5);
        fork
            record(103);
            begin
                repeat (5) @(negedge clk);
                drive(0, 1'b0, 9'h05A);
                repeat (10) @(negedge clk);
                drive(0, 1'b1, 9'h05A);
                repeat (3) @(negedge clk);
                drive(0, 1'b0, 9'h05A);
            end
        join
        decode(0, 10, obs, u);
        tests++;
        if (obs[9:0] !== 10'b1101001010 || u !== 0) begin
            fails++;
            $display("FAIL datachg_bits: got %b unstable %0d want 1101001010", obs[9:0], u);
        end
        tests++;
        if (dn[100] !== 1'b1 || count_done(0, 103) !== 1) begin
            fails++;
            $display("FAIL datachg_done: done@100=%b count=%0d want 1 1", dn[100], count_done(0, 103));
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_5n2();
        test_back_to_back();
        test_mid_reset();
        test_data_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
